// File: rtl/exponent_mentissa_normalizer_if.sv
`default_nettype none
// ============================================================================
// Module   : exponent_mentissa_normalizer_if
// Brief    : Upstream/downstream handshake and data bundle for the FP
//            normaliser stage.
// Revision : 1.0 - initial release
// ============================================================================
interface exponent_mentissa_normalizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
);
    localparam int c_POS_WIDTH = $clog2(MENT_WIDTH) + 1;

    logic                   valid_in;
    logic                   ready_out;
    logic                   sign_in;
    logic [EXPO_WIDTH-1:0]  exp_in;
    logic [MENT_WIDTH+1:0]  sum_in;
    logic [c_POS_WIDTH-1:0] normalize_position_in;
    logic [DATA_WIDTH-1:0]  result_out;
    logic                   valid_out;
    logic                   ready_in;
    logic                   overflow_out;
    logic                   underflow_out;
    logic                   zero_out;

    modport master (
        output valid_in, sign_in, exp_in, sum_in, normalize_position_in, ready_in,
        input  ready_out, result_out, valid_out, overflow_out, underflow_out, zero_out
    );

    modport slave (
        input  valid_in, sign_in, exp_in, sum_in, normalize_position_in, ready_in,
        output ready_out, result_out, valid_out, overflow_out, underflow_out, zero_out
    );
endinterface
`default_nettype wire

// File: rtl/exponent_mentissa_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : exponent_mentissa_normalizer
// Brief    : FP add/sub stage 4 - normalise mantissa, adjust exponent,
//            saturate/flush and pack the IEEE-754 single result (2 stages).
// Revision : 1.0 - initial release
// ============================================================================
module exponent_mentissa_normalizer #(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  wire logic                     clk_in,
    input  wire logic                     rst_n_in,
    exponent_mentissa_normalizer_if.slave bus
);
    localparam int c_POS_WIDTH = $clog2(MENT_WIDTH) + 1;
    localparam int c_E_WIDTH   = EXPO_WIDTH + 2;
    localparam int c_ZERO_POS  = MENT_WIDTH + 1;
    localparam int c_EXP_MAX   = (1 << EXPO_WIDTH) - 1;

    logic                   w_s1_load;
    logic                   w_s2_load;
    logic                   w_carry;
    logic                   w_zero;
    logic [MENT_WIDTH-1:0]  w_frac;
    logic [c_E_WIDTH-1:0]   w_exp;
    logic [c_E_WIDTH-1:0]   w_exp_ext;
    logic [c_E_WIDTH-1:0]   w_pos_ext;

    logic                   r_s1_valid;
    logic                   r_s1_sign;
    logic                   r_s1_zero;
    logic [c_E_WIDTH-1:0]   r_s1_exp;
    logic [MENT_WIDTH-1:0]  r_s1_frac;

    logic                   w_neg;
    logic                   w_ovf;
    logic                   w_unf;
    logic [DATA_WIDTH-1:0]  w_result;

    logic                   r_s2_valid;
    logic [DATA_WIDTH-1:0]  r_s2_result;
    logic                   r_s2_ovf;
    logic                   r_s2_unf;
    logic                   r_s2_zero;

    assign w_s2_load     = ~r_s2_valid | bus.ready_in;
    assign w_s1_load     = ~r_s1_valid | w_s2_load;
    assign bus.ready_out = w_s1_load;

    assign w_exp_ext = {2'b00, bus.exp_in};
    assign w_pos_ext = {{(c_E_WIDTH - c_POS_WIDTH){1'b0}}, bus.normalize_position_in};
    assign w_carry   = bus.sum_in[MENT_WIDTH+1];
    assign w_zero    = ~w_carry &
                       (bus.normalize_position_in == c_POS_WIDTH'(c_ZERO_POS));

    // Only the fraction is kept: the hidden bit always lands just above it.
    always_comb begin
        w_frac = '0;
        w_exp  = '0;
        if (w_carry) begin
            w_frac = bus.sum_in[MENT_WIDTH:1];
            w_exp  = w_exp_ext + c_E_WIDTH'(1);
        end else begin
            w_frac = bus.sum_in[MENT_WIDTH-1:0] << bus.normalize_position_in;
            w_exp  = w_exp_ext - w_pos_ext;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.valid_in;
            if (bus.valid_in) begin
                r_s1_sign <= bus.sign_in;
                r_s1_zero <= w_zero;
                r_s1_exp  <= w_exp;
                r_s1_frac <= w_frac;
            end
        end
    end

    // Working exponent is two's complement; the MSB marks a negative value.
    assign w_neg = r_s1_exp[c_E_WIDTH-1];
    assign w_ovf = ~r_s1_zero & ~w_neg & (r_s1_exp >= c_E_WIDTH'(c_EXP_MAX));
    assign w_unf = ~r_s1_zero & ~w_ovf & (w_neg | (r_s1_exp == '0));

    always_comb begin
        w_result = {r_s1_sign, r_s1_exp[EXPO_WIDTH-1:0], r_s1_frac};
        if (r_s1_zero) begin
            w_result = '0;
        end else if (w_ovf) begin
            w_result = {r_s1_sign, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
        end else if (w_unf) begin
            w_result = {r_s1_sign, {(DATA_WIDTH - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_ovf    <= 1'b0;
            r_s2_unf    <= 1'b0;
            r_s2_zero   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_result <= r_s1_valid ? w_result : '0;
            r_s2_ovf    <= r_s1_valid & w_ovf;
            r_s2_unf    <= r_s1_valid & w_unf;
            r_s2_zero   <= r_s1_valid & r_s1_zero;
        end
    end

    assign bus.valid_out     = r_s2_valid;
    assign bus.result_out    = r_s2_result;
    assign bus.overflow_out  = r_s2_ovf;
    assign bus.underflow_out = r_s2_unf;
    assign bus.zero_out      = r_s2_zero;

endmodule
`default_nettype wire

// File: tb/tb_exponent_mentissa_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exponent_mentissa_normalizer
// Brief    : Scoreboard bench for the FP normaliser stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exponent_mentissa_normalizer;
    logic clk;
    logic rst_n;

    exponent_mentissa_normalizer_if #(.DATA_WIDTH(32), .MENT_WIDTH(23), .EXPO_WIDTH(8)) bus ();

    exponent_mentissa_normalizer #(.DATA_WIDTH(32), .MENT_WIDTH(23), .EXPO_WIDTH(8)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_out    = 0;
    logic [34:0] sb_q[$];
    logic        rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {result[31:0], overflow, underflow, zero}
    function automatic logic [34:0] model(input logic sign, input logic [7:0] exp,
                                          input logic [24:0] sum, input logic [5:0] pos);
        int          e;
        logic [23:0] m;
        if (sum[24]) begin
            m = sum[24:1];
            e = int'(exp) + 1;
        end else if (pos == 6'd24) begin
            return {32'h0, 3'b001};
        end else begin
            m = sum[23:0] << pos;
            e = int'(exp) - int'(pos);
        end
        if (e >= 255) return {sign, 8'hFF, 23'h0, 3'b100};
        if (e <= 0)   return {sign, 31'h0, 3'b010};
        return {sign, e[7:0], m[22:0], 3'b000};
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.valid_out && bus.ready_in) begin
            n_out++;
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 64'(bus.result_out), 64'hDEAD_0000);
            end else begin
                logic [34:0] e;
                e = sb_q.pop_front();
                chk("result", 64'(bus.result_out), 64'(e[34:3]));
                chk("flags", 64'({bus.overflow_out, bus.underflow_out, bus.zero_out}), 64'(e[2:0]));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            if (rand_ready) bus.ready_in = 1'($urandom_range(0, 1));
        end
    end

    task automatic drive(input logic s, input logic [7:0] e, input logic [24:0] m, input logic [5:0] p);
        bus.valid_in              = 1'b1;
        bus.sign_in               = s;
        bus.exp_in                = e;
        bus.sum_in                = m;
        bus.normalize_position_in = p;
    endtask

    // Called at posedge+1; returns at posedge+1 after the operand is taken.
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input logic [5:0] p);
        bit done = 0;
        drive(s, e, m, p);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.ready_out) begin
                sb_q.push_back(model(s, e, m, p));
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        bus.valid_in = 1'b0;
    endtask

    task automatic drain();
        bus.ready_in = 1'b1;
        for (int i = 0; i < 200 && (sb_q.size() != 0 || bus.valid_out); i++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    logic [31:0] held;
    logic [5:0]  rp;
    logic [24:0] rs;
    int          out_before;

    initial begin
        rst_n = 1'b0;
        bus.valid_in = 1'b0;
        bus.sign_in = 1'b0;
        bus.exp_in = '0;
        bus.sum_in = '0;
        bus.normalize_position_in = '0;
        bus.ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_result", 64'(bus.result_out), 64'd0);
        chk("rst_flags", 64'({bus.overflow_out, bus.underflow_out, bus.zero_out}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(bus.ready_out), 64'd1);

        // Directed cases, including exponent boundaries
        send(1'b0, 8'd127, 25'h1800000, 6'd0);   // 3.0
        send(1'b0, 8'd127, 25'h0400000, 6'd1);   // 0.5
        send(1'b1, 8'd254, 25'h1000000, 6'd0);   // overflow
        send(1'b1, 8'd3,   25'h0020000, 6'd6);   // underflow
        send(1'b1, 8'd0,   25'h0000000, 6'd24);  // exact zero
        send(1'b0, 8'd254, 25'h0800000, 6'd0);   // E=254 largest normal
        send(1'b0, 8'd1,   25'h0800000, 6'd0);   // E=1 smallest normal
        send(1'b0, 8'd1,   25'h0400000, 6'd1);   // E=0 underflow
        send(1'b0, 8'd100, 25'h1800001, 6'd0);   // carry LSB truncated
        send(1'b0, 8'd255, 25'h0800000, 6'd0);   // E=255 saturates
        drain();

        // Stall: downstream blocked while operands stream in
        bus.ready_in = 1'b0;
        send(1'b0, 8'd10, 25'h0C00000, 6'd0);
        send(1'b1, 8'd20, 25'h0A00000, 6'd0);
        drive(1'b0, 8'd30, 25'h1400000, 6'd0);
        @(negedge clk);
        chk("stall_ready_drop", 64'(bus.ready_out), 64'd0);
        chk("stall_valid", 64'(bus.valid_out), 64'd1);
        held = bus.result_out;
        @(posedge clk);
        #1;
        bus.ready_in = 1'b1;
        @(negedge clk);
        chk("stall_hold", 64'(bus.result_out), 64'(held));
        chk("stall_ready_back", 64'(bus.ready_out), 64'd1);
        chk("nobubble_0", 64'(bus.valid_out), 64'd1);
        if (bus.ready_out) sb_q.push_back(model(1'b0, 8'd30, 25'h1400000, 6'd0));
        @(posedge clk);
        #1;
        drive(1'b1, 8'd40, 25'h0100000, 6'd3);
        @(negedge clk);
        chk("nobubble_1", 64'(bus.valid_out), 64'd1);
        if (bus.ready_out) sb_q.push_back(model(1'b1, 8'd40, 25'h0100000, 6'd3));
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        chk("nobubble_2", 64'(bus.valid_out), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("nobubble_3", 64'(bus.valid_out), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Random stream with random back-pressure
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rp = 6'($urandom_range(0, 24));
            if ($urandom_range(0, 3) == 0)
                rs = {1'b1, 24'($urandom)};
            else if (rp == 6'd24)
                rs = '0;
            else
                rs = (25'(1) << (23 - rp)) | (25'($urandom) & ((25'(1) << (23 - rp)) - 25'(1)));
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rs, rp);
        end
        rand_ready = 1'b0;
        drain();

        // Reset with two operands in flight
        bus.ready_in = 1'b0;
        send(1'b0, 8'd50, 25'h0800000, 6'd0);
        send(1'b0, 8'd60, 25'h0800000, 6'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("midrst_result", 64'(bus.result_out), 64'd0);
        sb_q.delete();
        out_before = n_out;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.ready_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_output", 64'(n_out), 64'(out_before));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
